// File: rtl/control_entrada_teclado.sv
// Keypad entry sequencer: builds {op_a, op_b, op_sel} from decoded keys and offers it downstream.
// Latency: key effect visible one clk after the key_valid cycle; command valid one clk after E.
// Backpressure: op_valid is held with stable operands until op_ready; keys arriving meanwhile are dropped.
module control_entrada_teclado #(
    parameter int MAX_DIGITS = 3,
    parameter int W          = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   key_value,
    input  logic         key_valid,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic         op_sel,
    output logic         op_valid,
    input  logic         op_ready,
    output logic [W-1:0] disp_value,
    output logic [1:0]   digit_cnt,
    output logic [1:0]   state_o
);

    typedef enum logic [1:0] {
        ENT_A = 2'd0,
        ENT_B = 2'd1,
        SEND  = 2'd2
    } state_t;

    localparam logic [1:0] CNT_MAX = 2'(MAX_DIGITS);

    localparam logic [3:0] KEY_ADD   = 4'hA;
    localparam logic [3:0] KEY_SUB   = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hE;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] op_a_nxt;
    logic [W-1:0] op_b_nxt;
    logic         op_sel_nxt;
    logic         op_valid_nxt;
    logic [1:0]   digit_cnt_nxt;

    logic         is_digit;
    logic         is_op;
    logic         is_clr;
    logic         is_ent;
    logic         digit_ok;
    logic [W-1:0] acc_cur;
    logic [W-1:0] acc_mul;

    // Key classification; D and F fall into no class and are ignored.
    always_comb begin
        is_digit = key_valid && (key_value <= 4'd9);
        is_op    = key_valid && ((key_value == KEY_ADD) || (key_value == KEY_SUB));
        is_clr   = key_valid && (key_value == KEY_CLR);
        is_ent   = key_valid && (key_value == KEY_ENTER);
        digit_ok = is_digit && (digit_cnt != CNT_MAX);
    end

    // Decimal shift-in of the operand being typed: acc*10 + digit, truncated to W bits.
    always_comb begin
        acc_cur = (state == ENT_A) ? op_a : op_b;
        acc_mul = (acc_cur << 3) + (acc_cur << 1) + {{(W-4){1'b0}}, key_value};
    end

    // Next-state and next-operand logic; hold everything unless a key or transfer says otherwise.
    always_comb begin
        state_nxt     = state;
        op_a_nxt      = op_a;
        op_b_nxt      = op_b;
        op_sel_nxt    = op_sel;
        op_valid_nxt  = op_valid;
        digit_cnt_nxt = digit_cnt;

        case (state)
            ENT_A: begin
                if (is_clr) begin
                    op_a_nxt      = '0;
                    op_b_nxt      = '0;
                    op_sel_nxt    = 1'b0;
                    digit_cnt_nxt = 2'd0;
                end else if (digit_ok) begin
                    op_a_nxt      = acc_mul;
                    digit_cnt_nxt = digit_cnt + 2'd1;
                end else if (is_op) begin
                    op_sel_nxt    = (key_value == KEY_SUB);
                    digit_cnt_nxt = 2'd0;
                    state_nxt     = ENT_B;
                end
            end

            ENT_B: begin
                if (is_clr) begin
                    op_a_nxt      = '0;
                    op_b_nxt      = '0;
                    op_sel_nxt    = 1'b0;
                    digit_cnt_nxt = 2'd0;
                    state_nxt     = ENT_A;
                end else if (digit_ok) begin
                    op_b_nxt      = acc_mul;
                    digit_cnt_nxt = digit_cnt + 2'd1;
                end else if (is_op && (digit_cnt == 2'd0)) begin
                    // Operator may be changed until the first B digit is typed.
                    op_sel_nxt    = (key_value == KEY_SUB);
                end else if (is_ent) begin
                    op_valid_nxt  = 1'b1;
                    state_nxt     = SEND;
                end
            end

            SEND: begin
                // Keys here are dropped, including one coinciding with the transfer edge.
                if (op_ready) begin
                    op_a_nxt      = '0;
                    op_b_nxt      = '0;
                    op_sel_nxt    = 1'b0;
                    op_valid_nxt  = 1'b0;
                    digit_cnt_nxt = 2'd0;
                    state_nxt     = ENT_A;
                end
            end

            default: begin
                op_a_nxt      = '0;
                op_b_nxt      = '0;
                op_sel_nxt    = 1'b0;
                op_valid_nxt  = 1'b0;
                digit_cnt_nxt = 2'd0;
                state_nxt     = ENT_A;
            end
        endcase
    end

    // State and operand registers; async reset drops any pending command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ENT_A;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= 1'b0;
            op_valid  <= 1'b0;
            digit_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            op_a      <= op_a_nxt;
            op_b      <= op_b_nxt;
            op_sel    <= op_sel_nxt;
            op_valid  <= op_valid_nxt;
            digit_cnt <= digit_cnt_nxt;
        end
    end

    // Display follows the operand being typed; B stays shown while the command waits.
    always_comb begin
        disp_value = (state == ENT_A) ? op_a : op_b;
        state_o    = state;
    end

endmodule

// File: doc/control_entrada_teclado.md
Name: control_entrada_teclado

Overview:
Sequences the keypad scanner's decoded key stream (4-bit key code plus a 1-clk valid pulse) into a two-operand arithmetic command.
Accumulates up to MAX_DIGITS decimal digits per operand, captures the operator, and issues {op_a, op_b, op_sel} to the downstream ALU/display stage over a valid/ready handshake.
Also drives the live entry value for the 7-segment display path.

Parameters:
MAX_DIGITS, 3, maximum decimal digits accepted per operand; extra digits are dropped.
W, 12, operand width in bits; must hold 10^MAX_DIGITS-1.

Ports:
clk  input  1  system clock (27 MHz)
rst_n  input  1  asynchronous active-low reset
key_value  input  4  key code from scanner, sampled only when key_valid=1
key_valid  input  1  1-clk pulse, new key available
op_a  output  W  first operand, binary
op_b  output  W  second operand, binary
op_sel  output  1  0 = add (key A), 1 = subtract (key B)
op_valid  output  1  command valid; held until accepted
op_ready  input  1  downstream accepts command when op_valid=1 at the same posedge
disp_value  output  W  operand currently being typed
digit_cnt  output  2  digits entered in the current operand (0..MAX_DIGITS)
state_o  output  2  FSM state for debug: 0 ENT_A, 1 ENT_B, 2 SEND

Behaviour:
- Clock and reset: all flops on posedge clk, async clear on negedge rst_n.
- Reset values: op_a=0, op_b=0, op_sel=0, op_valid=0, disp_value=0, digit_cnt=0, state=ENT_A.
- Key classes: 0-9 are digits; A and B are operators; C is clear-all; E is enter; D and F are ignored.
- Key sampling: keys are evaluated only in cycles with key_valid=1. Effect is visible on outputs on the next posedge (1-cycle latency).
- Digit accumulation:
  - New value = acc*10 + digit, implemented as (acc<<3)+(acc<<1)+digit, truncated to W bits.
  - If digit_cnt==MAX_DIGITS, the digit is ignored and nothing changes.
  - Leading zeros count as digits.
- ENT_A:
  - Digit: accumulates into op_a.
  - A or B: sets op_sel, goes to ENT_B, clears digit_cnt. Zero digits entered means op_a=0.
  - E: ignored.
  - disp_value=op_a.
- ENT_B:
  - Digit: accumulates into op_b.
  - A or B with digit_cnt==0: replaces op_sel and stays in ENT_B.
  - A or B with digit_cnt>0: ignored.
  - E: goes to SEND and sets op_valid=1 next cycle. Zero digits means op_b=0.
  - disp_value=op_b.
- SEND:
  - op_valid=1, and op_a, op_b, op_sel are stable.
  - All keys, including C, are ignored and dropped; no buffering.
  - Transfer occurs at the posedge where op_valid=1 and op_ready=1.
  - On the next cycle: op_valid=0, op_a=op_b=0, op_sel=0, digit_cnt=0, state=ENT_A, disp_value=0.
- C in ENT_A or ENT_B: same clear as the post-transfer clear, and op_valid stays 0.
- op_ready while not in SEND: ignored.
- op_valid never drops without a transfer, except on reset.
- Reset mid-operation (any state, including SEND with op_valid=1): immediate return to reset values; the pending command is lost.
- key_valid arriving in the same cycle as the transfer: the key is dropped, because state is still SEND.
- No arithmetic is performed in this block. Operands are passed unsigned; op_a<op_b is the downstream block's concern.

Test Plan:
- Reset, then keys 1,2,A,3,4,E -> one cycle after E: op_valid=1, op_a=12, op_b=34, op_sel=0, state_o=2. With op_ready=1 -> op_valid=0 next cycle, op_a=op_b=0, disp_value=0.
- Keys 9,8,7,6 in ENT_A -> op_a=987, digit_cnt=3, disp_value=987 (the 6 is dropped).
- Keys 5,A,B,7,E -> op_sel=1, op_a=5, op_b=7. Then key A after a B digit (keys 5,B,7,A,E) -> op_sel stays 1.
- Enter a command, hold op_ready=0 for 6 cycles while pulsing keys 1,C -> op_valid stays 1, operands unchanged. Raise op_ready -> exactly one transfer, and the next entry starts at op_a=0.
- Keys 4,5,C,2,A,E -> op_a=2, op_b=0, op_sel=0, op_valid=1. Also key E in ENT_A with no operator -> no state change.
- Drive rst_n low asynchronously mid-clock while in SEND with op_valid=1 -> all outputs go to zero immediately, before the next posedge, and state_o=0.
